// File: rtl/gpia_pkg.sv
// Shared definitions for the GPIA port controller: register map and bus FSM states.
package gpia_pkg;

  localparam logic [1:0] GPIA_ADR_OUT  = 2'd0;
  localparam logic [1:0] GPIA_ADR_DDR  = 2'd1;
  localparam logic [1:0] GPIA_ADR_IN   = 2'd2;
  localparam logic [1:0] GPIA_ADR_EDGE = 2'd3;

  typedef enum logic {
    ST_IDLE,
    ST_ACK
  } bus_state_e;

endpackage

// File: rtl/gpia_sync2.sv
// Single-bit two-flop synchroniser for an asynchronous pad input.
module gpia_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/gpia_port_ctrl.sv
// Wishbone-classic slave for one GPIA port: OUT/DDR registers, synchronised IN readback.
// Define GPIA_IRQ_EN to add rising-edge capture (EDGE, W1C) and a level interrupt.
module gpia_port_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cyc_i,
  input  logic             stb_i,
  input  logic             we_i,
  input  logic [1:0]       adr_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic [WIDTH-1:0] dat_o,
  output logic             ack_o,
  input  logic [WIDTH-1:0] port_i,
  output logic [WIDTH-1:0] port_o,
  output logic [WIDTH-1:0] ddr_o,
  output logic             irq_o
);

  import gpia_pkg::*;

  bus_state_e       state_q, state_d;
  logic             ack_q, ack_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] ddr_q, ddr_d;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] in_val;
  logic [WIDTH-1:0] edge_val;
  logic [WIDTH-1:0] rdata;
  logic             req;

  for (genvar i = 0; i < WIDTH; i++) begin : g_sync
    gpia_sync2 u_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (port_i[i]),
      .q_o   (sync[i])
    );
  end

  always_comb begin
    // A held strobe is re-accepted only after the ACK cycle, giving ack every other clock.
    req    = cyc_i & stb_i & (state_q == ST_IDLE);
    in_val = (ddr_q & out_q) | (~ddr_q & sync);
    unique case (adr_i)
      GPIA_ADR_OUT:  rdata = out_q;
      GPIA_ADR_DDR:  rdata = ddr_q;
      GPIA_ADR_IN:   rdata = in_val;
      GPIA_ADR_EDGE: rdata = edge_val;
      default:       rdata = '0;
    endcase
    state_d = req ? ST_ACK : ST_IDLE;
    ack_d   = req;
    dat_d   = req ? rdata : '0;
    out_d   = out_q;
    ddr_d   = ddr_q;
    if (req && we_i && (adr_i == GPIA_ADR_OUT)) out_d = dat_i;
    if (req && we_i && (adr_i == GPIA_ADR_DDR)) ddr_d = dat_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      out_q   <= '0;
      ddr_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      out_q   <= out_d;
      ddr_q   <= ddr_d;
    end
  end

`ifdef GPIA_IRQ_EN
  logic [WIDTH-1:0] sync_dly_q, sync_dly_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic             irq_q, irq_d;
  logic [WIDTH-1:0] clr;

  always_comb begin
    sync_dly_d = sync;
    clr        = (req && we_i && (adr_i == GPIA_ADR_EDGE)) ? dat_i : '0;
    // New rising edge takes priority over a simultaneous clear.
    edge_d     = (edge_q & ~clr) | (sync & ~sync_dly_q & ~ddr_q);
    irq_d      = |edge_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_dly_q <= '0;
      edge_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      sync_dly_q <= sync_dly_d;
      edge_q     <= edge_d;
      irq_q      <= irq_d;
    end
  end

  assign edge_val = edge_q;
  assign irq_o    = irq_q;
`else
  assign edge_val = '0;
  assign irq_o    = 1'b0;
`endif

  assign ack_o  = ack_q;
  assign dat_o  = dat_q;
  assign port_o = out_q;
  assign ddr_o  = ddr_q;

endmodule

// File: tb/tb_gpia_port_ctrl.sv
// Randomised and directed bench for gpia_port_ctrl against a behavioural register/pin model.
module tb_gpia_port_ctrl;

  localparam int W = 16;
`ifdef GPIA_IRQ_EN
  localparam bit IrqEn = 1'b1;
`else
  localparam bit IrqEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         cyc_i, stb_i, we_i;
  logic [1:0]   adr_i;
  logic [W-1:0] dat_i, dat_o, port_i, port_o, ddr_o;
  logic         ack_o, irq_o;

  int total = 0;
  int bad   = 0;
  bit run_chk = 1'b0;

  // Model state: register contents, last bus response, and history of sampled pins.
  logic [W-1:0] m_out, m_ddr, m_edge, m_dat;
  logic         m_ack, m_irq;
  logic [W-1:0] hist[$];

  gpia_port_ctrl #(.WIDTH(W)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .cyc_i  (cyc_i),
    .stb_i  (stb_i),
    .we_i   (we_i),
    .adr_i  (adr_i),
    .dat_i  (dat_i),
    .dat_o  (dat_o),
    .ack_o  (ack_o),
    .port_i (port_i),
    .port_o (port_o),
    .ddr_o  (ddr_o),
    .irq_o  (irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_out = '0; m_ddr = '0; m_edge = '0; m_dat = '0; m_ack = 1'b0; m_irq = 1'b0;
    hist = '{'0, '0, '0};
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst && run_chk) begin
      chk("ack", ack_o, m_ack);
      chk("dat", dat_o, m_dat);
      chk("port_o", port_o, m_out);
      chk("ddr_o", ddr_o, m_ddr);
      chk("irq", irq_o, m_irq);
    end
  end

  // Drive one clock of inputs, advance the model across the edge, return 2 units after it.
  task automatic step(input logic c, input logic s, input logic w, input logic [1:0] a,
                      input logic [W-1:0] d, input logic [W-1:0] p);
    logic         req;
    logic [W-1:0] sync, rdata, rise, clr;
    cyc_i = c; stb_i = s; we_i = w; adr_i = a; dat_i = d; port_i = p;
    req  = c & s & ~m_ack;
    sync = hist[1];
    case (a)
      2'd0:    rdata = m_out;
      2'd1:    rdata = m_ddr;
      2'd2:    rdata = (m_ddr & m_out) | (~m_ddr & sync);
      default: rdata = m_edge;
    endcase
    rise = IrqEn ? (hist[1] & ~hist[2] & ~m_ddr) : '0;
    clr  = (req && w && a == 2'd3) ? d : '0;
    m_irq = IrqEn ? (|m_edge) : 1'b0;
    m_edge = IrqEn ? ((m_edge & ~clr) | rise) : '0;
    m_ack = req;
    m_dat = req ? rdata : '0;
    if (req && w && a == 2'd0) m_out = d;
    if (req && w && a == 2'd1) m_ddr = d;
    hist.push_front(p);
    void'(hist.pop_back());
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_ack", ack_o, 1'b0);
    chk("rst_port_o", port_o, '0);
    chk("rst_ddr_o", ddr_o, '0);
    chk("rst_dat", dat_o, '0);
    chk("rst_irq", irq_o, 1'b0);
    #1;
    rst = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [W-1:0] d, input logic [W-1:0] p);
    step(1'b1, 1'b1, 1'b1, a, d, p);
    step(1'b0, 1'b0, 1'b0, 2'd0, '0, p);
  endtask

  task automatic rd_lit(input string name, input logic [1:0] a, input logic [W-1:0] p,
                        input logic [W-1:0] exp);
    step(1'b1, 1'b1, 1'b0, a, '0, p);
    chk(name, dat_o, exp);
    step(1'b0, 1'b0, 1'b0, 2'd0, '0, p);
  endtask

  task automatic idle(input int n, input logic [W-1:0] p);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 2'd0, '0, p);
  endtask

  initial begin
    rst = 1'b1;
    cyc_i = 0; stb_i = 0; we_i = 0; adr_i = 0; dat_i = '0; port_i = '0;
    model_reset();
    #1;
    chk("reset_ack", ack_o, 1'b0);
    chk("reset_port_o", port_o, '0);
    chk("reset_irq", irq_o, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    run_chk = 1'b1;

    // Reset during the ACK cycle of a write.
    step(1'b1, 1'b1, 1'b1, 2'd0, 16'hBEEF, '0);
    chk("pre_rst_port_o", port_o, 16'hBEEF);
    do_reset();
    idle(1, '0);

    // Mixed-direction readback.
    wr(2'd0, 16'hA5A5, 16'h1234);
    wr(2'd1, 16'hFF00, 16'h1234);
    idle(3, 16'h1234);
    rd_lit("in_mixed", 2'd2, 16'h1234, 16'hA534);

    // Held strobe: ack every other clock, each carrying OUT.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b0, 2'd0, '0, 16'h1234);
      chk("held_ack", ack_o, (i % 2 == 0));
      if (i % 2 == 0) chk("held_dat", dat_o, 16'hA5A5);
    end
    idle(1, 16'h1234);

    // Synchroniser latency on bit0 (input since DDR[0]=0).
    idle(3, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 2'd0, '0, 16'h0001);
    step(1'b1, 1'b1, 1'b0, 2'd2, '0, 16'h0001);
    chk("sync_early", dat_o[0], 1'b0);
    idle(1, 16'h0000);
    idle(3, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 2'd0, '0, 16'h0001);
    step(1'b0, 1'b0, 1'b0, 2'd0, '0, 16'h0001);
    step(1'b1, 1'b1, 1'b0, 2'd2, '0, 16'h0001);
    chk("sync_visible", dat_o[0], 1'b1);
    idle(1, 16'h0000);

    // Edge capture and W1C.
    wr(2'd1, 16'h0000, 16'h0000);
    idle(3, 16'h0000);
    wr(2'd3, 16'hFFFF, 16'h0000);
    idle(2, 16'h0000);
    chk("irq_clear0", irq_o, 1'b0);
    idle(4, 16'h0008);
    chk("irq_set", irq_o, IrqEn);
    rd_lit("edge_set", 2'd3, 16'h0008, IrqEn ? 16'h0008 : 16'h0000);
    wr(2'd3, 16'h0008, 16'h0008);
    idle(1, 16'h0008);
    chk("irq_cleared", irq_o, 1'b0);
    rd_lit("edge_cleared", 2'd3, 16'h0008, 16'h0000);

    // Rising edge lands on the same clock as its W1C: set wins.
    idle(4, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 2'd0, '0, 16'h0008);
    step(1'b0, 1'b0, 1'b0, 2'd0, '0, 16'h0008);
    step(1'b1, 1'b1, 1'b1, 2'd3, 16'h0008, 16'h0008);
    idle(1, 16'h0008);
    rd_lit("edge_set_wins", 2'd3, 16'h0008, IrqEn ? 16'h0008 : 16'h0000);

    // Random traffic.
    begin
      logic [W-1:0] p;
      p = '0;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 99) == 0) do_reset();
        if ($urandom_range(0, 3) == 0) p = W'($urandom);
        step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), 1'($urandom),
             2'($urandom), W'($urandom), p);
      end
    end

    run_chk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
